uart_rx_param: RTL and testbench

//  Parametrised UART receiver: the next generation of uart_top's fixed 8N1 RX path.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_param.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the parametrised UART receiver: parity modes and FSM states.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling FSM, shift register and a one-deep
// valid/ready holding register with framing, parity and overrun flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] rx,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  rx_state_e            state;
  rx_state_e            state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_cnt_nxt;
  logic                 line_s;
  logic                 half_tick;
  logic                 bit_tick;
  logic                 shift_en;
  logic                 par_en;
  logic                 stop_en;
  logic                 done_nxt;
  logic                 done_p0;
  logic                 ferr_p0;
  logic [DATA_BITS-1:0] shift_p0;
  logic                 pbit_p0;

  function automatic logic calc_parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    logic odd_ones;
    odd_ones = ^{d, p};
    if (PARITY == PAR_ODD)  return ~odd_ones;
    if (PARITY == PAR_EVEN) return odd_ones;
    return 1'b0;
  endfunction

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_data),
    .q   (line_s)
  );

  assign half_tick = (cnt == HALF_M1);
  assign bit_tick  = (cnt == FULL_M1);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_cnt_nxt = bit_cnt;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt     = '0;
        bit_cnt_nxt = '0;
        if (!line_s) state_nxt = ST_START;
      end
      ST_START: begin
        if (half_tick) begin
          cnt_nxt   = '0;
          state_nxt = line_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          cnt_nxt  = '0;
          shift_en = 1'b1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          cnt_nxt   = '0;
          par_en    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          cnt_nxt = '0;
          stop_en = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_nxt = '0;
            done_nxt    = 1'b1;
            // A low final stop means the line is held low: wait it out before re-arming.
            state_nxt   = line_s ? ST_IDLE : ST_BREAK;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        cnt_nxt = '0;
        if (line_s) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt   = ST_IDLE;
        cnt_nxt     = '0;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      done_p0 <= 1'b0;
      ferr_p0 <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      done_p0 <= done_nxt;
      if (state == ST_IDLE) ferr_p0 <= 1'b0;
      else if (stop_en && !line_s) ferr_p0 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift_p0 <= {line_s, shift_p0[DATA_BITS-1:1]};
    if (par_en)   pbit_p0  <= line_s;
  end

  // Holding register stage: loads one cycle after the final stop sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx         <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (done_p0) begin
      rx         <= shift_p0;
      frame_err  <= ferr_p0;
      parity_err <= calc_parity_err(shift_p0, pbit_p0);
      rx_valid   <= 1'b1;
      if (rx_valid && !rx_ready) overrun <= 1'b1;
      else if (rx_valid)         overrun <= 1'b0;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed-plus-random bench for uart_rx_param: an 8N1 instance and a 7E2 instance
// driven by a bit-level line model, checked against frame-level expectations.
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       line0 = 1'b1;
  logic       line1 = 1'b1;
  logic       rdy0 = 1'b0;
  logic       rdy1 = 1'b0;
  logic [7:0] rx0;
  logic [6:0] rx1;
  logic       valid0, valid1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;
  int         tests = 0;
  int         fails = 0;

  always #1 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .rx_data(line0), .rx(rx0), .rx_valid(valid0), .rx_ready(rdy0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(busy0)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .rx_data(line1), .rx(rx1), .rx_valid(valid1), .rx_ready(rdy1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(busy1)
  );

  task automatic check1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [8:0] got, input logic [8:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Even parity is violated when data plus parity bit carry an odd number of ones.
  function automatic logic even_par_err(input logic [6:0] d, input logic p);
    return ((($countones(d) + int'(p)) % 2) == 1);
  endfunction

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic put(input int which, input logic b);
    if (which == 0) line0 = b;
    else line1 = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input int which, input logic [8:0] data, input int nbits,
                      input bit has_par, input logic pbit, input logic [1:0] stops,
                      input int nstops, input int tail);
    @(negedge clk);
    put(which, 1'b0);
    for (int i = 0; i < nbits; i++) put(which, data[i]);
    if (has_par) put(which, pbit);
    for (int i = 0; i < nstops; i++) put(which, stops[i]);
    for (int i = 0; i < tail; i++) put(which, 1'b1);
  endtask

  task automatic handshake(input int which);
    @(negedge clk);
    if (which == 0) rdy0 = 1'b1;
    else rdy1 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
    rdy1 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [7:0] d8;
    logic [6:0] d7;
    logic [1:0] st;
    logic       pb;
    bit         got;
    bit         saw_busy;
    logic [7:0] cap_rx;
    logic       cap_fe, cap_pe, cap_next;

    cap_rx = 'x; cap_fe = 1'bx; cap_pe = 1'bx; cap_next = 1'bx;

    repeat (3) @(negedge clk);
    checkw("reset_rx", 9'(rx0), 9'h000);
    check1("reset_valid", valid0, 1'b0);
    check1("reset_fe", fe0, 1'b0);
    check1("reset_pe", pe0, 1'b0);
    check1("reset_ov", ov0, 1'b0);
    check1("reset_busy", busy0, 1'b0);
    check1("reset_valid1", valid1, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single 8N1 frame with the consumer always ready: one-cycle valid pulse.
    rdy0 = 1'b1;
    got  = 1'b0;
    fork
      send(0, 9'h041, 8, 1'b0, 1'b0, 2'b11, 1, 2);
      begin
        for (int i = 0; i < 12 * CPB && !got; i++) begin
          @(negedge clk);
          if (valid0) begin
            got = 1'b1; cap_rx = rx0; cap_fe = fe0; cap_pe = pe0;
          end
        end
        @(negedge clk);
        cap_next = valid0;
      end
    join
    rdy0 = 1'b0;
    check1("8n1_seen", got, 1'b1);
    checkw("8n1_rx", 9'(cap_rx), 9'h041);
    check1("8n1_fe", cap_fe, 1'b0);
    check1("8n1_pe", cap_pe, 1'b0);
    check1("8n1_pulse", cap_next, 1'b0);
    check1("8n1_ov", ov0, 1'b0);

    // Two frames back to back with nobody reading: second overwrites the first.
    send(0, 9'h041, 8, 1'b0, 1'b0, 2'b11, 1, 0);
    send(0, 9'h044, 8, 1'b0, 1'b0, 2'b11, 1, 2);
    check1("b2b_valid", valid0, 1'b1);
    checkw("b2b_rx", 9'(rx0), 9'h044);
    check1("b2b_ov", ov0, 1'b1);
    check1("b2b_fe", fe0, 1'b0);
    handshake(0);
    check1("b2b_valid_clr", valid0, 1'b0);
    check1("b2b_ov_clr", ov0, 1'b0);

    // Low stop bit followed by a held-low line.
    send(0, 9'h041, 8, 1'b0, 1'b0, 2'b00, 1, 0);
    check1("brk_valid", valid0, 1'b1);
    checkw("brk_rx", 9'(rx0), 9'h041);
    check1("brk_fe", fe0, 1'b1);
    check1("brk_busy", busy0, 1'b1);
    handshake(0);
    wait_bits(5);
    check1("brk_no_frame", valid0, 1'b0);
    check1("brk_still_busy", busy0, 1'b1);
    line0 = 1'b1;
    wait_bits(2);
    check1("brk_idle", busy0, 1'b0);
    check1("brk_no_frame2", valid0, 1'b0);

    // Short low glitch: receiver wakes, rejects the start and produces nothing.
    saw_busy = 1'b0;
    @(negedge clk);
    line0 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 2) line0 = 1'b1;
      if (busy0) saw_busy = 1'b1;
    end
    check1("glitch_busy_seen", saw_busy, 1'b1);
    check1("glitch_busy_end", busy0, 1'b0);
    wait_bits(2);
    check1("glitch_valid", valid0, 1'b0);

    // Reset in the middle of data bit 4, then a clean frame.
    fork
      send(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1, 2);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkw("midrst_rx", 9'(rx0), 9'h000);
        check1("midrst_valid", valid0, 1'b0);
        check1("midrst_fe", fe0, 1'b0);
        check1("midrst_pe", pe0, 1'b0);
        check1("midrst_ov", ov0, 1'b0);
        check1("midrst_busy", busy0, 1'b0);
      end
    join
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 9'h055, 8, 1'b0, 1'b0, 2'b11, 1, 2);
    check1("post_rst_valid", valid0, 1'b1);
    checkw("post_rst_rx", 9'(rx0), 9'h055);
    check1("post_rst_fe", fe0, 1'b0);
    check1("post_rst_ov", ov0, 1'b0);
    handshake(0);

    // Even parity instance: 0x41 has two ones, so pbit=1 is wrong and pbit=0 is right.
    send(1, 9'h041, 7, 1'b1, 1'b1, 2'b11, 2, 2);
    check1("par1_valid", valid1, 1'b1);
    checkw("par1_rx", 9'(rx1), 9'h041);
    check1("par1_pe", pe1, 1'b1);
    check1("par1_fe", fe1, 1'b0);
    handshake(1);
    send(1, 9'h041, 7, 1'b1, 1'b0, 2'b11, 2, 2);
    check1("par0_valid", valid1, 1'b1);
    check1("par0_pe", pe1, 1'b0);
    check1("par0_ov", ov1, 1'b0);
    handshake(1);
    check1("par_valid_clr", valid1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      d8 = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
      send(0, {1'b0, d8}, 8, 1'b0, 1'b0, st, 1, 2);
      check1("rnd8_valid", valid0, 1'b1);
      checkw("rnd8_rx", 9'(rx0), {1'b0, d8});
      check1("rnd8_fe", fe0, (st[0] == 1'b0));
      check1("rnd8_pe", pe0, 1'b0);
      check1("rnd8_ov", ov0, 1'b0);
      handshake(0);
    end

    for (int n = 0; n < 6; n++) begin
      d7 = 7'($urandom_range(0, 127));
      pb = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send(1, {2'b00, d7}, 7, 1'b1, pb, st, 2, 2);
      check1("rnd7_valid", valid1, 1'b1);
      checkw("rnd7_rx", 9'(rx1), {2'b00, d7});
      check1("rnd7_pe", pe1, even_par_err(d7, pb));
      check1("rnd7_fe", fe1, (st != 2'b11));
      check1("rnd7_ov", ov1, 1'b0);
      check1("rnd7_busy", busy1, 1'b0);
      handshake(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
